// File: rtl/execute_if.sv
// -----------------------------------------------------------------------------
// execute_if
// Pipeline bundle between the decode stage, the EX stage and the EX/MEM
// register consumers.
//   i_pipe_*     : operands and control of the instruction currently in EX
//   i_ctl_Flush  : kill request from the memory stage
//   o_ctl_Stall  : combinational hold request back to the upstream stages
//   o_pipe_*     : registered EX/MEM pipeline register contents
// Modports:
//   slave  : the EX stage itself (consumes i_*, produces o_*)
//   master : the surrounding pipeline / testbench
// -----------------------------------------------------------------------------
interface execute_if;
    logic [31:0] i_pipe_PC;
    logic [31:0] i_pipe_Reg1Data;
    logic [31:0] i_pipe_Reg2Data;
    logic [31:0] i_pipe_Imm;
    logic [4:0]  i_pipe_RegDst;
    logic [3:0]  i_pipe_AluOp;
    logic        i_pipe_AluSrc;
    logic        i_pipe_MemToReg;
    logic        i_pipe_RegWrEn;
    logic        i_pipe_MemWrEn;
    logic        i_pipe_Branch;
    logic        i_pipe_Jump;
    logic        i_ctl_Flush;

    logic        o_ctl_Stall;
    logic [31:0] o_pipe_TargetAddr;
    logic [31:0] o_pipe_AluResult;
    logic        o_pipe_Zero;
    logic [31:0] o_pipe_Reg2Data;
    logic [4:0]  o_pipe_RegDst;
    logic        o_pipe_MemToReg;
    logic        o_pipe_RegWrEn;
    logic        o_pipe_MemWrEn;
    logic        o_pipe_Branch;
    logic        o_pipe_Jump;

    modport slave (
        input  i_pipe_PC, i_pipe_Reg1Data, i_pipe_Reg2Data, i_pipe_Imm,
               i_pipe_RegDst, i_pipe_AluOp, i_pipe_AluSrc, i_pipe_MemToReg,
               i_pipe_RegWrEn, i_pipe_MemWrEn, i_pipe_Branch, i_pipe_Jump,
               i_ctl_Flush,
        output o_ctl_Stall, o_pipe_TargetAddr, o_pipe_AluResult, o_pipe_Zero,
               o_pipe_Reg2Data, o_pipe_RegDst, o_pipe_MemToReg, o_pipe_RegWrEn,
               o_pipe_MemWrEn, o_pipe_Branch, o_pipe_Jump
    );

    modport master (
        output i_pipe_PC, i_pipe_Reg1Data, i_pipe_Reg2Data, i_pipe_Imm,
               i_pipe_RegDst, i_pipe_AluOp, i_pipe_AluSrc, i_pipe_MemToReg,
               i_pipe_RegWrEn, i_pipe_MemWrEn, i_pipe_Branch, i_pipe_Jump,
               i_ctl_Flush,
        input  o_ctl_Stall, o_pipe_TargetAddr, o_pipe_AluResult, o_pipe_Zero,
               o_pipe_Reg2Data, o_pipe_RegDst, o_pipe_MemToReg, o_pipe_RegWrEn,
               o_pipe_MemWrEn, o_pipe_Branch, o_pipe_Jump
    );
endinterface

// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute
// EX stage of the light RV32I pipeline. Selects ALU operands, computes the
// ALU result, zero flag and PC+Imm target, and registers them together with
// the pass-through control/data into the EX/MEM register. MUL runs on a
// 32-step shift-add multiplier that holds the upstream stages via Stall.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : execute_if.slave (pipeline inputs, flush, stall, EX/MEM outputs)
// Parameter:
//   MUL_EN  : 1 enables the multiplier; 0 makes MUL return 0 with no stall
// -----------------------------------------------------------------------------
module execute #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    execute_if.slave  bus
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_PASSB = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q,  state_d;
    logic [4:0]  count_q,  count_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q,    acc_d;

    logic [31:0] tgt_q,  tgt_d;
    logic [31:0] res_q,  res_d;
    logic        zero_q, zero_d;
    logic [31:0] r2_q,   r2_d;
    logic [4:0]  rd_q,   rd_d;
    logic        m2r_q,  m2r_d;
    logic        rwe_q,  rwe_d;
    logic        mwe_q,  mwe_d;
    logic        br_q,   br_d;
    logic        jmp_q,  jmp_d;

    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [4:0]  shamt_s;
    logic        mul_req_s;
    logic        stall_s;
    logic [31:0] alu_res_s;

    assign op_a_s    = bus.i_pipe_Reg1Data;
    assign op_b_s    = bus.i_pipe_AluSrc ? bus.i_pipe_Imm : bus.i_pipe_Reg2Data;
    assign shamt_s   = op_b_s[4:0];
    assign mul_req_s = (MUL_EN == 1'b1) && (bus.i_pipe_AluOp == OP_MUL);

    // Stall request: a MUL waiting in IDLE or a multiply in progress. Flush
    // overrides it so the killed instruction never holds the pipe; reset
    // keeps it low because the FSM cannot accept work while reset is held.
    always_comb begin
        stall_s = 1'b0;
        if (!reset_n || bus.i_ctl_Flush) begin
            stall_s = 1'b0;
        end else if (state_q == S_IDLE) begin
            stall_s = mul_req_s;
        end else if (state_q == S_BUSY) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // ALU datapath; MUL only yields a product in the DONE cycle.
    always_comb begin
        alu_res_s = 32'd0;
        case (bus.i_pipe_AluOp)
            OP_ADD:   alu_res_s = op_a_s + op_b_s;
            OP_SUB:   alu_res_s = op_a_s - op_b_s;
            OP_AND:   alu_res_s = op_a_s & op_b_s;
            OP_OR:    alu_res_s = op_a_s | op_b_s;
            OP_XOR:   alu_res_s = op_a_s ^ op_b_s;
            OP_SLL:   alu_res_s = op_a_s << shamt_s;
            OP_SRL:   alu_res_s = op_a_s >> shamt_s;
            OP_SRA:   alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
            OP_SLT:   alu_res_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU:  alu_res_s = {31'd0, (op_a_s < op_b_s)};
            OP_PASSB: alu_res_s = op_b_s;
            OP_MUL: begin
                if ((MUL_EN == 1'b1) && (state_q == S_DONE)) begin
                    alu_res_s = acc_q;
                end else begin
                    alu_res_s = 32'd0;
                end
            end
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Multiplier FSM next-state: flush aborts from any state and drops the
    // partial product; BUSY adds the shifted multiplicand for each set bit.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (bus.i_ctl_Flush) begin
            state_d  = S_IDLE;
            count_d  = 5'd0;
            mcand_d  = 32'd0;
            mplier_d = 32'd0;
            acc_d    = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_req_s) begin
                        state_d  = S_BUSY;
                        count_d  = 5'd0;
                        mcand_d  = op_a_s;
                        mplier_d = op_b_s;
                        acc_d    = 32'd0;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (mplier_q[count_q]) begin
                        acc_d = acc_q + (mcand_q << count_q);
                    end else begin
                        acc_d = acc_q;
                    end
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    count_d = 5'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = 5'd0;
                    acc_d   = 32'd0;
                end
            endcase
        end
    end

    // EX/MEM register next values: bubble on flush or stall, else results.
    always_comb begin
        tgt_d  = 32'd0;
        res_d  = 32'd0;
        zero_d = 1'b0;
        r2_d   = 32'd0;
        rd_d   = 5'd0;
        m2r_d  = 1'b0;
        rwe_d  = 1'b0;
        mwe_d  = 1'b0;
        br_d   = 1'b0;
        jmp_d  = 1'b0;
        if (bus.i_ctl_Flush || stall_s) begin
            tgt_d = 32'd0;
        end else begin
            tgt_d  = bus.i_pipe_PC + bus.i_pipe_Imm;
            res_d  = bus.i_pipe_Jump ? (bus.i_pipe_PC + 32'd4) : alu_res_s;
            zero_d = (alu_res_s == 32'd0);
            r2_d   = bus.i_pipe_Reg2Data;
            rd_d   = bus.i_pipe_RegDst;
            m2r_d  = bus.i_pipe_MemToReg;
            rwe_d  = bus.i_pipe_RegWrEn;
            mwe_d  = bus.i_pipe_MemWrEn;
            br_d   = bus.i_pipe_Branch;
            jmp_d  = bus.i_pipe_Jump;
        end
    end

    // State and pipeline registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            tgt_q    <= 32'd0;
            res_q    <= 32'd0;
            zero_q   <= 1'b0;
            r2_q     <= 32'd0;
            rd_q     <= 5'd0;
            m2r_q    <= 1'b0;
            rwe_q    <= 1'b0;
            mwe_q    <= 1'b0;
            br_q     <= 1'b0;
            jmp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            tgt_q    <= tgt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            r2_q     <= r2_d;
            rd_q     <= rd_d;
            m2r_q    <= m2r_d;
            rwe_q    <= rwe_d;
            mwe_q    <= mwe_d;
            br_q     <= br_d;
            jmp_q    <= jmp_d;
        end
    end

    assign bus.o_ctl_Stall       = stall_s;
    assign bus.o_pipe_TargetAddr = tgt_q;
    assign bus.o_pipe_AluResult  = res_q;
    assign bus.o_pipe_Zero       = zero_q;
    assign bus.o_pipe_Reg2Data   = r2_q;
    assign bus.o_pipe_RegDst     = rd_q;
    assign bus.o_pipe_MemToReg   = m2r_q;
    assign bus.o_pipe_RegWrEn    = rwe_q;
    assign bus.o_pipe_MemWrEn    = mwe_q;
    assign bus.o_pipe_Branch     = br_q;
    assign bus.o_pipe_Jump       = jmp_q;

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute
// Self-checking bench for the EX stage: a table of ALU/branch vectors with
// constant expectations, randomized instructions checked against an
// arithmetic reference model, and hand-written multiply/flush/reset sequences.
// -----------------------------------------------------------------------------
module tb_execute;

    logic clk;
    logic reset_n;

    execute_if bus ();

    execute #(.MUL_EN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        src;
        logic        m2r;
        logic        rwe;
        logic        mwe;
        logic        br;
        logic        jmp;
    } in_t;

    typedef struct packed {
        logic [31:0] tgt;
        logic [31:0] res;
        logic        zero;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        m2r;
        logic        rwe;
        logic        mwe;
        logic        br;
        logic        jmp;
    } out_t;

    typedef struct {
        string       name;
        in_t         v;
        logic [31:0] res;
        logic        zero;
        logic [31:0] tgt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    localparam out_t BUBBLE = '0;

    // Reference ALU using plain arithmetic (shifts as multiply/divide by 2^n).
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] pw;
        int unsigned sh;
        sh = b % 32;
        pw = 32'd1 << sh;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: begin p = {32'd0, a} * {32'd0, pw}; return p[31:0]; end
            4'h6: return a / pw;
            4'h7: return a[31] ? ~((~a) / pw) : (a / pw);
            4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return b;
            4'hB: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic out_t ref_out(input in_t v);
        out_t e;
        logic [31:0] alu;
        alu   = ref_alu(v.op, v.r1, v.src ? v.imm : v.r2);
        e.tgt  = v.pc + v.imm;
        e.res  = v.jmp ? (v.pc + 32'd4) : alu;
        e.zero = (alu == 32'd0);
        e.r2   = v.r2;
        e.rd   = v.rd;
        e.m2r  = v.m2r;
        e.rwe  = v.rwe;
        e.mwe  = v.mwe;
        e.br   = v.br;
        e.jmp  = v.jmp;
        return e;
    endfunction

    function automatic in_t mk(input logic [3:0] op, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] imm,
                               input logic src, input logic [31:0] pc,
                               input logic jmp, input logic rwe);
        in_t v;
        v.pc = pc; v.r1 = r1; v.r2 = r2; v.imm = imm; v.rd = 5'd7;
        v.op = op; v.src = src; v.m2r = 1'b0; v.rwe = rwe; v.mwe = 1'b0;
        v.br = 1'b0; v.jmp = jmp;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.pc  = $urandom() & 32'hFFFF_FFFC;
        v.r1  = $urandom();
        v.r2  = ($urandom_range(0, 7) == 0) ? v.r1 : $urandom();
        v.imm = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() & 32'h0000_003F);
        v.rd  = 5'($urandom_range(0, 31));
        v.op  = 4'($urandom_range(0, 15));
        v.src = 1'($urandom_range(0, 1));
        v.m2r = 1'($urandom_range(0, 1));
        v.rwe = 1'($urandom_range(0, 1));
        v.mwe = 1'($urandom_range(0, 1));
        v.br  = 1'($urandom_range(0, 1));
        v.jmp = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        return v;
    endfunction

    task automatic drive(input in_t v, input logic fl);
        bus.i_pipe_PC       = v.pc;
        bus.i_pipe_Reg1Data = v.r1;
        bus.i_pipe_Reg2Data = v.r2;
        bus.i_pipe_Imm      = v.imm;
        bus.i_pipe_RegDst   = v.rd;
        bus.i_pipe_AluOp    = v.op;
        bus.i_pipe_AluSrc   = v.src;
        bus.i_pipe_MemToReg = v.m2r;
        bus.i_pipe_RegWrEn  = v.rwe;
        bus.i_pipe_MemWrEn  = v.mwe;
        bus.i_pipe_Branch   = v.br;
        bus.i_pipe_Jump     = v.jmp;
        bus.i_ctl_Flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act.tgt  = bus.o_pipe_TargetAddr;
        act.res  = bus.o_pipe_AluResult;
        act.zero = bus.o_pipe_Zero;
        act.r2   = bus.o_pipe_Reg2Data;
        act.rd   = bus.o_pipe_RegDst;
        act.m2r  = bus.o_pipe_MemToReg;
        act.rwe  = bus.o_pipe_RegWrEn;
        act.mwe  = bus.o_pipe_MemWrEn;
        act.br   = bus.o_pipe_Branch;
        act.jmp  = bus.o_pipe_Jump;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got tgt=%h res=%h z=%b r2=%h rd=%0d ctl=%b%b%b%b%b, want tgt=%h res=%h z=%b r2=%h rd=%0d ctl=%b%b%b%b%b",
                     name, act.tgt, act.res, act.zero, act.r2, act.rd,
                     act.m2r, act.rwe, act.mwe, act.br, act.jmp,
                     exp.tgt, exp.res, exp.zero, exp.r2, exp.rd,
                     exp.m2r, exp.rwe, exp.mwe, exp.br, exp.jmp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        n_vec++;
        if (bus.o_ctl_Stall !== exp) begin
            n_err++;
            $display("FAIL %s: stall got %b want %b", name, bus.o_ctl_Stall, exp);
        end
    endtask

    // Single-cycle instruction: no stall, result registered at the next edge.
    task automatic apply(input string name, input in_t v, input out_t exp);
        drive(v, 1'b0);
        #1;
        check_stall({name, " stall"}, 1'b0);
        tick();
        check_out(name, exp);
    endtask

    // Full multiply: 33 stall cycles of bubbles, then the product.
    task automatic run_mul(input string name, input in_t v);
        drive(v, 1'b0);
        for (int i = 0; i < 33; i++) begin
            #1;
            check_stall({name, " busy stall"}, 1'b1);
            tick();
            check_out({name, " bubble"}, BUBBLE);
        end
        #1;
        check_stall({name, " done stall"}, 1'b0);
        tick();
        check_out(name, ref_out(v));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        in_t  v;
        in_t  w;
        out_t e;

        // ---------------- reset with random inputs ----------------
        reset_n = 1'b0;
        drive(rand_in(), 1'b0);
        #2;
        check_out("reset initial", BUBBLE);
        check_stall("reset initial stall", 1'b0);
        for (int i = 0; i < 4; i++) begin
            v = rand_in();
            if (i == 1) v.op = 4'hB;
            drive(v, 1'($urandom_range(0, 1)));
            #1;
            check_stall("reset hold stall", 1'b0);
            tick();
            check_out("reset hold", BUBBLE);
        end
        reset_n = 1'b1;
        v = mk(4'h0, 32'd5, 32'd7, 32'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        e = ref_out(v);
        e.res = 32'd12;
        e.zero = 1'b0;
        apply("first add", v, e);

        // ---------------- table-driven ALU / branch vectors ----------------
        tbl.push_back('{"add",   mk(4'h0, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h8000_0001, 1'b0, 32'h1010});
        tbl.push_back('{"sub",   mk(4'h1, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h7FFF_FFFF, 1'b0, 32'h1010});
        tbl.push_back('{"and",   mk(4'h2, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h1010});
        tbl.push_back('{"or",    mk(4'h3, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h8000_0001, 1'b0, 32'h1010});
        tbl.push_back('{"xor",   mk(4'h4, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h8000_0001, 1'b0, 32'h1010});
        tbl.push_back('{"sll",   mk(4'h5, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h1010});
        tbl.push_back('{"srl",   mk(4'h6, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h4000_0000, 1'b0, 32'h1010});
        tbl.push_back('{"sra",   mk(4'h7, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'hC000_0000, 1'b0, 32'h1010});
        tbl.push_back('{"slt",   mk(4'h8, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0001, 1'b0, 32'h1010});
        tbl.push_back('{"sltu",  mk(4'h9, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h1010});
        tbl.push_back('{"passb", mk(4'hA, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0001, 1'b0, 32'h1010});
        tbl.push_back('{"op_c",  mk(4'hC, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h1010});
        tbl.push_back('{"op_f",  mk(4'hF, 32'h8000_0000, 32'd1, 32'h10, 1'b0, 32'h1000, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h1010});
        tbl.push_back('{"sub_zero",  mk(4'h1, 32'd9, 32'd9, 32'h0, 1'b0, 32'h200, 1'b0, 1'b1), 32'h0000_0000, 1'b1, 32'h0200});
        tbl.push_back('{"add_imm",   mk(4'h0, 32'd100, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h10, 1'b0, 1'b1), 32'd99, 1'b0, 32'h0000_000F});
        tbl.push_back('{"sra_imm31", mk(4'h7, 32'h8000_0000, 32'd0, 32'h3F, 1'b1, 32'h0, 1'b0, 1'b0), 32'hFFFF_FFFF, 1'b0, 32'h0000_003F});
        tbl.push_back('{"jump",      mk(4'h0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h100, 1'b1, 1'b1), 32'h0000_0104, 1'b1, 32'h0000_0120});
        for (int i = 0; i < tbl.size(); i++) begin
            e = ref_out(tbl[i].v);
            e.res  = tbl[i].res;
            e.zero = tbl[i].zero;
            e.tgt  = tbl[i].tgt;
            apply(tbl[i].name, tbl[i].v, e);
        end

        // ---------------- multiply corner cases ----------------
        run_mul("mul ffffffff*3", mk(4'hB, 32'hFFFF_FFFF, 32'd3, 32'h4, 1'b0, 32'h40, 1'b0, 1'b1));
        run_mul("mul 0*x", mk(4'hB, 32'd0, 32'h1234_5678, 32'h4, 1'b0, 32'h40, 1'b0, 1'b1));
        run_mul("mul imm", mk(4'hB, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFF9, 1'b1, 32'h80, 1'b0, 1'b1));

        // ---------------- flush during BUSY (count 10) ----------------
        v = mk(4'hB, 32'd123, 32'd456, 32'h0, 1'b0, 32'h300, 1'b0, 1'b1);
        drive(v, 1'b0);
        for (int i = 0; i < 11; i++) begin
            #1;
            check_stall("flush busy pre stall", 1'b1);
            tick();
        end
        drive(v, 1'b1);
        #1;
        check_stall("flush busy stall drop", 1'b0);
        tick();
        check_out("flush busy bubble", BUBBLE);
        w = mk(4'h0, 32'd3, 32'd4, 32'h8, 1'b0, 32'h500, 1'b0, 1'b1);
        apply("after flush busy", w, ref_out(w));

        // ---------------- flush together with MUL / ADD ----------------
        drive(v, 1'b1);
        #1;
        check_stall("flush+mul stall", 1'b0);
        tick();
        check_out("flush+mul bubble", BUBBLE);
        apply("after flush+mul", w, ref_out(w));
        drive(w, 1'b1);
        tick();
        check_out("flush add rwe", BUBBLE);

        // ---------------- async reset without clock edge ----------------
        apply("pre reset add", w, ref_out(w));
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async reset outputs", BUBBLE);
        tick();
        reset_n = 1'b1;

        // ---------------- async reset mid-MUL (count 20) ----------------
        drive(v, 1'b0);
        for (int i = 0; i < 21; i++) begin
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_out("reset mid mul", BUBBLE);
        check_stall("reset mid mul stall", 1'b0);
        tick();
        check_out("reset mid mul held", BUBBLE);
        reset_n = 1'b1;
        run_mul("mul after reset", mk(4'hB, 32'd7, 32'd6, 32'h0, 1'b0, 32'h600, 1'b0, 1'b1));

        // ---------------- randomized against the reference model ----------------
        for (int i = 0; i < 150; i++) begin
            v = rand_in();
            if (v.op == 4'hB) begin
                run_mul("rand mul", v);
            end else begin
                apply("rand op", v, ref_out(v));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
